s27_bist_ctrl: RTL and testbench
================================

Name: s27_bist_ctrl

Overview:
Built-in self-test controller that drives the stimulus side of the s27 sequential core (G0..G3) and compacts its response (G17).
- Flush phase: applies a fixed initialisation vector so the reset-less s27 flops reach a known state.
- Run phase: applies N_PATTERNS LFSR vectors and folds G17 into a 16-bit signature register.
- Result: the signature is compared against a golden value and reported as PASS/DONE to the test sequencer.

Parameters:
N_PATTERNS, 64, number of LFSR vectors applied in RUN (1..1023)
INIT_CYCLES, 3, number of cycles INIT_VEC is held in INIT (>=3)
INIT_VEC, 4'b1100, flush vector {G3,G2,G1,G0}; forces G7=0, G5=0, then G6=1
LFSR_SEED, 4'b0001, non-zero seed of the 4-bit stimulus LFSR
SIG_POLY, 16'h1021, Galois feedback polynomial of the signature register
GOLDEN_SIG, 16'h0000, expected signature; set per build from the gate-level reference run

Ports:
CK     input   1   clock; all state updates on the rising edge
RST    input   1   synchronous active-high reset
START  input   1   request a test run; sampled only in IDLE and DONE
G0     output  1   stimulus bit 0 to s27
G1     output  1   stimulus bit 1 to s27
G2     output  1   stimulus bit 2 to s27
G3     output  1   stimulus bit 3 to s27
G17    input   1   s27 response; combinational from s27 state and G0..G3
BUSY   output  1   high in INIT and RUN
DONE   output  1   high in DONE state
PASS   output  1   SIG==GOLDEN_SIG; valid only while DONE=1, 0 otherwise
SIG    output  16  current signature register value

Behaviour:
- Clocking and reset: one clock, CK. Reset is synchronous and active-high on RST.
- Reset values (RST=1 at a CK edge):
  - state=IDLE; G3..G0=4'b0000; BUSY=0; DONE=0; PASS=0.
  - SIG=16'h0000; LFSR=LFSR_SEED; cycle counter=0.
  - RST overrides START and applies in any state, including mid-RUN. A reset run is abandoned with no partial result.
- All outputs are registered. G0..G3 change only on CK edges.
- IDLE:
  - G=4'b0000.
  - START=1 moves to INIT at the next edge: counter cleared, SIG cleared to 16'h0000, LFSR reloaded with LFSR_SEED.
- INIT:
  - G=INIT_VEC for exactly INIT_CYCLES cycles. Counter counts 0..INIT_CYCLES-1.
  - G17 is ignored and SIG is held at 0.
  - On the last count, move to RUN. The first RUN cycle presents LFSR_SEED on G.
- RUN:
  - Cycle k (k=0..N_PATTERNS-1) presents LFSR state k on {G3,G2,G1,G0}.
  - At the end of each RUN cycle the edge does the following:
    - SIG <= ({SIG[14:0],1'b0} ^ (SIG[15] ? SIG_POLY : 16'h0)) ^ {15'b0,G17}.
    - LFSR <= {LFSR[2:0], LFSR[3]^LFSR[2]} (x^4+x^3+1, period 15; wraps through all non-zero states).
    - Counter increments.
  - After the edge capturing pattern N_PATTERNS-1, move to DONE.
  - START is ignored in RUN.
- DONE:
  - G=4'b0000. SIG frozen. DONE=1. PASS=(SIG==GOLDEN_SIG), registered on entry.
  - START=1 re-enters INIT with the same clearing as from IDLE.
  - Without START, the block stays in DONE indefinitely.
- Counter width: $clog2(max(N_PATTERNS,INIT_CYCLES)+1). No overflow is possible within the legal parameter ranges.
- Latency from START to DONE: 1 + INIT_CYCLES + N_PATTERNS edges, i.e. 68 with the defaults.
- START held high across a run: the run is not restarted mid-run. A new run starts one cycle after DONE is reached.

Decomposition:
- Package s27_bist_pkg:
  - state enum {IDLE, INIT, RUN, DONE}, 2 bits.
  - Constants: LFSR tap positions, default SIG_POLY, default INIT_VEC.
- Sub-module sig_misr16 (CK, RST, CLR, EN, DIN, SIG) holds the signature register. It is reused later for other ISCAS cores.
- The LFSR and FSM stay inline.

Test Plan:
1. Reset, then START held low for 10 cycles -> BUSY=0, DONE=0, PASS=0, G=4'b0000, SIG=16'h0000 throughout.
2. START one-cycle pulse -> G3..G0=1100 for 3 cycles, then 0001, 0010, 0100, 1001, 0011, 0110, 1101; DONE rises exactly 68 edges after START is sampled; BUSY is high for 67 cycles.
3. Bench ties G17=0 -> final SIG=16'h0000 and PASS=1 with GOLDEN_SIG=0; with G17=1 only in RUN cycle 0 and N_PATTERNS=1 -> SIG=16'h0001 and PASS=0.
4. Connected to the gate-level s27 netlist -> SIG matches the C reference model of s27+LFSR for 64 patterns; PASS=1 when GOLDEN_SIG is set to that value; flipping one G17 bit via force -> PASS=0.
5. RST asserted in RUN cycle 20 -> next edge: IDLE, G=0000, SIG=0; START issued afterwards gives a full run with an identical signature.
6. START held high continuously, plus START re-pulsed in DONE -> runs execute back-to-back, SIG restarts from 16'h0000 and the same signature repeats; no run restarts mid-RUN.

Source files
------------

// File: rtl/s27_bist_pkg.sv
// Shared types, constants and step functions for the s27 BIST controller.
// The state enum, LFSR taps, default vectors and the LFSR/MISR next-state
// helpers live here so that later ISCAS BIST controllers can reuse them.
package s27_bist_pkg;

  localparam int unsigned LFSR_W      = 4;
  localparam int unsigned SIG_W       = 16;
  localparam int unsigned LFSR_TAP_HI = 3;
  localparam int unsigned LFSR_TAP_LO = 2;

  localparam logic [SIG_W-1:0]  DEF_SIG_POLY  = 16'h1021;
  localparam logic [LFSR_W-1:0] DEF_INIT_VEC  = 4'b1100;
  localparam logic [LFSR_W-1:0] DEF_LFSR_SEED = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // x^4+x^3+1 Fibonacci step: walks all 15 non-zero states
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

  // Galois signature step with the response bit folded into bit 0
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic din,
                                                 input logic [SIG_W-1:0] poly);
    return ({s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? poly : '0)) ^ {{(SIG_W-1){1'b0}}, din};
  endfunction

endpackage

// File: rtl/s27_bist_ctrl_misr.sv
// 16-bit single-input signature register (sig_misr16).
// Ports: CK clock, RST sync active-high reset, CLR sync clear,
//        EN fold DIN this edge, DIN response bit, SIG signature value.
module sig_misr16
  import s27_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = DEF_SIG_POLY
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  input  logic             DIN,
  output logic [SIG_W-1:0] SIG
);

  always_ff @(posedge CK) begin
    if (RST || CLR) begin
      SIG <= '0;
    end else if (EN) begin
      SIG <= misr_next(SIG, DIN, POLY);
    end
  end

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST controller for the s27 core: flushes it with INIT_VEC, applies
// N_PATTERNS LFSR vectors on G3..G0, compacts G17 into SIG and reports
// PASS/DONE.
// Ports: CK clock, RST sync active-high reset, START run request,
//        G0..G3 stimulus, G17 response, BUSY (INIT/RUN), DONE, PASS, SIG.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int unsigned         N_PATTERNS  = 64,
  parameter int unsigned         INIT_CYCLES = 3,
  parameter logic [LFSR_W-1:0]   INIT_VEC    = DEF_INIT_VEC,
  parameter logic [LFSR_W-1:0]   LFSR_SEED   = DEF_LFSR_SEED,
  parameter logic [SIG_W-1:0]    SIG_POLY    = DEF_SIG_POLY,
  parameter logic [SIG_W-1:0]    GOLDEN_SIG  = 16'h0000
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  output logic             G0,
  output logic             G1,
  output logic             G2,
  output logic             G3,
  input  logic             G17,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIG
);

  localparam int unsigned CNT_MAX = (N_PATTERNS > INIT_CYCLES) ? N_PATTERNS : INIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt;
  logic [LFSR_W-1:0] gvec, gvec_nxt;
  logic              busy, busy_nxt;
  logic              done, done_nxt;
  logic              pass, pass_nxt;
  logic              misr_clr, misr_en;

  // State and registered outputs
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      lfsr  <= LFSR_SEED;
      gvec  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lfsr  <= lfsr_nxt;
      gvec  <= gvec_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      pass  <= pass_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lfsr_nxt  = lfsr;
    gvec_nxt  = gvec;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    misr_clr  = 1'b0;
    misr_en   = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
          lfsr_nxt  = LFSR_SEED;
          misr_clr  = 1'b1;
          gvec_nxt  = INIT_VEC;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
        end
      end
      ST_INIT: begin
        if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          gvec_nxt  = lfsr;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        misr_en  = 1'b1;
        lfsr_nxt = lfsr_next(lfsr);
        gvec_nxt = lfsr_next(lfsr);
        cnt_nxt  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(N_PATTERNS - 1)) begin
          state_nxt = ST_DONE;
          gvec_nxt  = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          // Judge the signature as it will be after this final fold
          pass_nxt  = (misr_next(SIG, G17, SIG_POLY) == GOLDEN_SIG);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sig_misr16 #(
    .POLY (SIG_POLY)
  ) u_misr (
    .CK  (CK),
    .RST (RST),
    .CLR (misr_clr),
    .EN  (misr_en),
    .DIN (G17),
    .SIG (SIG)
  );

  assign G0   = gvec[0];
  assign G1   = gvec[1];
  assign G2   = gvec[2];
  assign G3   = gvec[3];
  assign BUSY = busy;
  assign DONE = done;
  assign PASS = pass;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Self-checking bench for s27_bist_ctrl: random G17 responses are scored
// against a behavioural model of the stimulus sequence and signature.
module tb_s27_bist_ctrl;

  localparam int          NPAT     = 64;
  localparam int          NINIT    = 3;
  localparam int          RUN_LEN  = 1 + NINIT + NPAT;
  localparam logic [3:0]  INIT_V   = 4'b1100;
  localparam logic [3:0]  SEED     = 4'b0001;
  localparam logic [15:0] POLY     = 16'h1021;
  localparam logic [15:0] GOLDEN   = 16'h0000;

  logic        CK = 1'b0;
  logic        RST, START, G17;
  logic        G0, G1, G2, G3, BUSY, DONE, PASS;
  logic [15:0] SIG;

  logic        start1, g17_1;
  logic        h0, h1, h2, h3, busy1, done1, pass1;
  logic [15:0] sig1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_g [NPAT];
  bit         resp  [NPAT];

  always #5 CK = ~CK;

  s27_bist_ctrl dut (
    .CK(CK), .RST(RST), .START(START),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3), .G17(G17),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .SIG(SIG)
  );

  s27_bist_ctrl #(.N_PATTERNS(1)) dut1 (
    .CK(CK), .RST(RST), .START(start1),
    .G0(h0), .G1(h1), .G2(h2), .G3(h3), .G17(g17_1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .SIG(sig1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Signature as a polynomial over GF(2): multiply by x, reduce, add response
  function automatic logic [15:0] model_sig(input logic [15:0] s, input bit d);
    int v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ int'(POLY);
    return 16'(v ^ int'(d));
  endfunction

  function automatic logic [3:0] model_lfsr(input logic [3:0] s);
    int v, fb;
    v  = int'(s);
    fb = ((v / 8) ^ (v / 4)) % 2;
    return 4'(((v * 2) % 16) + fb);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_g"},    {G3, G2, G1, G0}, 4'b0000);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_done"}, DONE, 1'b0);
    check({tag, "_pass"}, PASS, 1'b0);
    check({tag, "_sig"},  SIG,  16'h0000);
  endtask

  // One full run; START is sampled at edge 1, DONE must appear after edge RUN_LEN.
  // abort_at>0 asserts RST in the cycle before that edge and stops the run there.
  task automatic run_one(input string tag, input bit hold, input int abort_at,
                         output logic [15:0] fsig);
    logic [15:0] s;
    s    = 16'h0000;
    fsig = 16'h0000;
    START = 1'b1;
    for (int e = 1; e <= RUN_LEN; e++) begin
      if (e >= 2 + NINIT) G17 = resp[e - 2 - NINIT];
      else                G17 = 1'($urandom_range(1, 0));
      if (e == abort_at) RST = 1'b1;
      tick();
      if (!hold) START = 1'b0;
      if (e == abort_at) begin
        RST = 1'b0;
        check_idle({tag, "_abort"});
        return;
      end
      if (e >= 2 + NINIT) s = model_sig(s, resp[e - 2 - NINIT]);
      if (e <= NINIT) begin
        check({tag, "_init_g"},    {G3, G2, G1, G0}, INIT_V);
        check({tag, "_init_busy"}, BUSY, 1'b1);
        check({tag, "_init_done"}, DONE, 1'b0);
        check({tag, "_init_sig"},  SIG,  16'h0000);
      end else if (e < RUN_LEN) begin
        check({tag, "_run_g"},    {G3, G2, G1, G0}, exp_g[e - 1 - NINIT]);
        check({tag, "_run_busy"}, BUSY, 1'b1);
        check({tag, "_run_done"}, DONE, 1'b0);
        check({tag, "_run_sig"},  SIG,  s);
      end else begin
        check({tag, "_end_g"},    {G3, G2, G1, G0}, 4'b0000);
        check({tag, "_end_busy"}, BUSY, 1'b0);
        check({tag, "_end_done"}, DONE, 1'b1);
        check({tag, "_end_sig"},  SIG,  s);
        check({tag, "_end_pass"}, PASS, (s == GOLDEN));
      end
    end
    fsig = s;
  endtask

  task automatic hold_done(input string tag, input int n, input logic [15:0] s);
    START = 1'b0;
    for (int i = 0; i < n; i++) begin
      G17 = 1'($urandom_range(1, 0));
      tick();
      check({tag, "_done"}, DONE, 1'b1);
      check({tag, "_sig"},  SIG,  s);
      check({tag, "_g"},    {G3, G2, G1, G0}, 4'b0000);
      check({tag, "_pass"}, PASS, (s == GOLDEN));
    end
  endtask

  initial begin
    logic [15:0] sig_a, sig_b, sig_c, sig_d, sig_e, sig_f;

    exp_g[0] = SEED;
    for (int k = 1; k < NPAT; k++) exp_g[k] = model_lfsr(exp_g[k - 1]);

    RST = 1'b1; START = 1'b0; G17 = 1'b0; start1 = 1'b0; g17_1 = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    check_idle("reset");
    for (int i = 0; i < 10; i++) begin
      G17 = 1'($urandom_range(1, 0));
      tick();
      check_idle("idle");
    end

    // All-zero response: signature stays zero and matches the golden value
    for (int k = 0; k < NPAT; k++) resp[k] = 1'b0;
    run_one("zero", 1'b0, 0, sig_a);
    hold_done("zero_hold", 3, sig_a);

    // Random response compacted into a non-trivial signature
    for (int k = 0; k < NPAT; k++) resp[k] = 1'($urandom_range(1, 0));
    run_one("rand", 1'b0, 0, sig_b);
    hold_done("rand_hold", 3, sig_b);

    // Reset during RUN cycle 20, then a clean rerun of the same responses
    run_one("abort", 1'b0, 2 + NINIT + 20, sig_c);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("post_abort");
    end
    run_one("rerun", 1'b0, 0, sig_d);
    check("rerun_same_sig", SIG, sig_b);
    hold_done("rerun_hold", 2, sig_d);

    // START held high: back-to-back runs, each restarting from a clear signature
    run_one("held1", 1'b1, 0, sig_e);
    run_one("held2", 1'b1, 0, sig_f);
    check("held_same_sig", SIG, sig_b);
    hold_done("held_hold", 2, sig_f);

    // Single-pattern instance: response 1 only in RUN cycle 0
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("one_init_g", {h3, h2, h1, h0}, INIT_V);
    tick();
    tick();
    tick();
    check("one_run_g",    {h3, h2, h1, h0}, SEED);
    check("one_run_busy", busy1, 1'b1);
    g17_1 = 1'b1;
    tick();
    g17_1 = 1'b0;
    check("one_done", done1, 1'b1);
    check("one_busy", busy1, 1'b0);
    check("one_sig",  sig1,  model_sig(16'h0000, 1'b1));
    check("one_pass", pass1, 1'b0);
    check("one_g",    {h3, h2, h1, h0}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
